// File: rtl/run_dump_controller.sv
// Run controller: holds the core in reset, runs it until halt (plus drain) or timeout,
// then streams data memory followed by the register file out over valid/ready.
module run_dump_controller #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned MEM_WORDS    = 64,
  parameter int unsigned REG_COUNT    = 32,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 14,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  output logic              cpu_reset,
  output logic              rd_en,
  output logic              rd_is_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_is_reg,
  output logic [ADDR_W-1:0] dump_index,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  typedef enum logic [2:0] {
    StIdle, StRst, StRun, StDrain, StRd, StWait, StPresent, StDone
  } state_e;

  localparam logic [15:0] RstLast   = 16'((RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0);
  localparam logic [15:0] DrainLast = 16'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  MaxCnt  = CNT_W'(MAX_CYCLES);
  localparam logic [ADDR_W-1:0] MemLast = ADDR_W'(MEM_WORDS - 1);
  localparam logic [ADDR_W-1:0] RegLast = ADDR_W'((REG_COUNT > 0) ? REG_COUNT - 1 : 0);

  state_e              state_q, state_d;
  logic [15:0]         aux_q, aux_d;      // shared by RST and DRAIN, never live together
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                to_q, to_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic                phase_q, phase_d;  // 0 = memory, 1 = register file
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   dindex_q, dindex_d;
  logic                dreg_q, dreg_d;

  assign cnt_inc = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    aux_d    = aux_q;
    cycle_d  = cycle_q;
    to_d     = to_q;
    index_d  = index_q;
    phase_d  = phase_q;
    data_d   = data_q;
    dindex_d = dindex_q;
    dreg_d   = dreg_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRst;
          aux_d   = '0;
          cycle_d = '0;
          to_d    = 1'b0;
          index_d = '0;
          phase_d = 1'b0;
        end
      end
      StRst: begin
        if (aux_q == RstLast) begin
          state_d = StRun;
        end else begin
          aux_d = aux_q + 16'd1;
        end
      end
      StRun: begin
        cycle_d = cnt_inc;
        if (halt) begin
          aux_d = '0;
          if (DRAIN_CYCLES == 0) state_d = StRd;
          else                   state_d = StDrain;
        end else if ((MAX_CYCLES != 0) && (cnt_inc == MaxCnt)) begin
          to_d    = 1'b1;
          state_d = StRd;
        end
      end
      StDrain: begin
        cycle_d = cnt_inc;
        if (aux_q == DrainLast) begin
          state_d = StRd;
        end else begin
          aux_d = aux_q + 16'd1;
        end
      end
      StRd: state_d = StWait;
      StWait: begin
        data_d   = rd_data;
        dindex_d = index_q;
        dreg_d   = phase_q;
        state_d  = StPresent;
      end
      StPresent: begin
        if (dump_ready) begin
          if (!phase_q) begin
            if (index_q == MemLast) begin
              if (REG_COUNT > 0) begin
                phase_d = 1'b1;
                index_d = '0;
                state_d = StRd;
              end else begin
                state_d = StDone;
              end
            end else begin
              index_d = index_q + ADDR_W'(1);
              state_d = StRd;
            end
          end else if (index_q == RegLast) begin
            state_d = StDone;
          end else begin
            index_d = index_q + ADDR_W'(1);
            state_d = StRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      aux_q    <= '0;
      cycle_q  <= '0;
      to_q     <= 1'b0;
      index_q  <= '0;
      phase_q  <= 1'b0;
      data_q   <= '0;
      dindex_q <= '0;
      dreg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      aux_q    <= aux_d;
      cycle_q  <= cycle_d;
      to_q     <= to_d;
      index_q  <= index_d;
      phase_q  <= phase_d;
      data_q   <= data_d;
      dindex_q <= dindex_d;
      dreg_q   <= dreg_d;
    end
  end

  assign cpu_reset   = (state_q == StIdle) || (state_q == StRst);
  assign rd_en       = (state_q == StRd);
  assign rd_addr     = rd_en ? index_q : '0;
  assign rd_is_reg   = rd_en & phase_q;
  assign dump_valid  = (state_q == StPresent);
  assign dump_data   = data_q;
  assign dump_index  = dindex_q;
  assign dump_is_reg = dreg_q;
  assign cycle_count = cycle_q;
  assign timed_out   = to_q;
  assign done        = (state_q == StDone);
  assign busy        = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: doc/run_dump_controller.md
Name: run_dump_controller

Overview:
- Run controller for the pipelined processor: holds the core in reset, releases it on `start`, and counts execution cycles.
- Ends the run on a halt indication (after a pipeline drain) or on a cycle timeout.
- Then sequences a read-out of data memory followed by the register file over a one-cycle-latency read port.
- Streams each word out through a valid/ready interface.

Parameters:
- DATA_W, 32, width of memory/register words
- ADDR_W, 6, index width; must satisfy 2^ADDR_W >= max(MEM_WORDS, REG_COUNT)
- MEM_WORDS, 64, number of memory words dumped (indices 0..MEM_WORDS-1)
- REG_COUNT, 32, number of registers dumped; 0 = skip register dump
- RESET_CYCLES, 1, cycles cpu_reset is held after start (>=1)
- MAX_CYCLES, 14, run-cycle timeout; 0 = no timeout
- DRAIN_CYCLES, 4, extra cycles run after halt before dumping (0 allowed)
- CNT_W, 16, cycle counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin run (honoured only in IDLE or DONE)
- halt  in  1  processor reports halt retired
- cpu_reset  out  1  reset to processor
- rd_en  out  1  read strobe
- rd_is_reg  out  1  0 = memory, 1 = register file
- rd_addr  out  ADDR_W  read index
- rd_data  in  DATA_W  read data, valid the cycle after rd_en
- dump_valid  out  1  dump word valid
- dump_ready  in  1  consumer accepts
- dump_data  out  DATA_W  dumped word
- dump_is_reg  out  1  source of dump_data
- dump_index  out  ADDR_W  index of dump_data
- cycle_count  out  CNT_W  cycles spent in RUN+DRAIN
- busy  out  1  not in IDLE/DONE
- done  out  1  dump complete
- timed_out  out  1  run ended by MAX_CYCLES

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous, active-high.
- On reset, next state is IDLE, with:
  - cpu_reset=1
  - all other outputs 0
  - index 0
- Reset mid-operation aborts immediately; no partial dump resumes.

States:
- IDLE: cpu_reset=1. start -> RST; clear cycle_count, timed_out, index.
- RST: cpu_reset=1 for exactly RESET_CYCLES cycles -> RUN.
- RUN: cpu_reset=0; cycle_count increments each cycle (saturating). Exits, evaluated after the increment:
  - halt=1 -> DRAIN (halt has priority over timeout; timed_out stays 0).
  - Otherwise, if MAX_CYCLES!=0 and the new count == MAX_CYCLES -> RD with timed_out=1.
- DRAIN: cpu_reset=0; cycle_count keeps incrementing; after DRAIN_CYCLES cycles -> RD. DRAIN_CYCLES=0 goes straight to RD. halt is ignored.
- RD: rd_en=1 for one cycle with rd_addr=index and rd_is_reg -> WAIT.
- WAIT: register rd_data into dump_data; latch dump_index and dump_is_reg -> PRESENT.
- PRESENT: dump_valid=1. dump_data, dump_index and dump_is_reg are held stable until dump_ready=1. On handshake:
  - Memory phase, index < MEM_WORDS-1: index+1 -> RD.
  - Last memory word: if REG_COUNT>0, switch to registers with index=0 -> RD; else -> DONE.
  - Register phase, last register: -> DONE.
- DONE: done=1; cpu_reset stays 0 so the processor state is preserved. cycle_count and timed_out are held. start -> RST; clear done, timed_out, cycle_count, index.

Other rules:
- start while busy=1 is ignored.
- busy=1 in RST, RUN, DRAIN, RD, WAIT, PRESENT.
- rd_en is never asserted outside RD, and is never asserted while dump_valid=1.
- Throughput: minimum 3 cycles per word. Total handshakes = MEM_WORDS+REG_COUNT.

Test Plan:
- Defaults, halt=0, dump_ready=1, start pulse:
  - cpu_reset low after 1 cycle.
  - Timeout gives cycle_count=14, timed_out=1.
  - 64 memory words (index 0..63) then 32 register words (0..31) stream in order, matching the preloaded model.
  - done=1 after handshake 96.
- halt pulsed on the 5th RUN cycle: 4 DRAIN cycles, cycle_count=9 at the first rd_en, timed_out=0.
- dump_ready held low 3 cycles while word 10 is presented: dump_data/dump_index stay constant, no rd_en issued, no word lost or duplicated.
- reset asserted during register dump (index 7): next cycle IDLE, cpu_reset=1, dump_valid=0, busy=0, done=0. A new start dumps from memory index 0.
- halt asserted in the same cycle the count reaches MAX_CYCLES: enters DRAIN, timed_out=0. REG_COUNT=0 build: done right after memory word 63.
- start pulsed during RUN: no effect. start in DONE: done cleared next cycle, cpu_reset=1 for RESET_CYCLES, full rerun.
